sccb_slave_responder: RTL
=========================

SCCB_SLAVE_RESPONDER -- requirements
Module: sccb_slave_responder

Interface
REQ-001 SHALL have parameter SLAVE_ID, default 7'h21, meaning the 7-bit device ID (write byte 8'h42, read byte 8'h43).
REQ-002 SHALL have parameter REG_DEPTH, default 16, meaning the number of 8-bit registers (sub-addresses 0..REG_DEPTH-1).
REQ-003 SHALL have port clk  input  1  system clock; single clock domain.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port sio_c  input  1  SCCB serial clock from the master.
REQ-006 SHALL have port sio_d  inout  1  SCCB serial data; driven only when the responder drives, else 'z'.
REQ-007 SHALL have port host_raddr_i  input  8  local register read address.
REQ-008 SHALL have port host_rdata_o  output  8  register[host_raddr_i], combinational; 8'h00 if out of range.
REQ-009 SHALL have port wr_evt_o  output  1  one-cycle pulse per committed SCCB register write.
REQ-010 SHALL have port wr_addr_o / wr_data_o  output  8 each  sub-address/data of the last committed write.
REQ-011 SHALL have port busy_o  output  1  high from a detected START until the next STOP.

Function
REQ-012 SHALL pass sio_c and sio_d through 2-flop synchronisers; all detection uses synchronised values; clk SHALL be ≥8× sio_c frequency.
REQ-013 SHALL detect START as sio_d falling while sio_c high and STOP as sio_d rising while sio_c high, both from any state.
REQ-014 SHALL sample input bits on synchronised sio_c rising edge, MSB first, and change driven bits only on synchronised sio_c falling edge.
REQ-015 SHALL implement states IDLE, ID, ID_ACK, SUB, SUB_ACK, WDATA, WDATA_ACK, RDATA, RD_NA, IGNORE.
REQ-016 START -> ID from any state; STOP -> IDLE from any state, without committing a partial byte.
REQ-017 ID: after 8 bits, ID[7:1]==SLAVE_ID -> ID_ACK; else -> IGNORE (no sio_d drive until STOP).
REQ-018 ID_ACK (9th bit) -> SUB if R/W=0, -> RDATA if R/W=1.
REQ-019 SUB: 8 bits latch sub-address pointer -> SUB_ACK -> WDATA.
REQ-020 WDATA: 8 bits -> WDATA_ACK; write commits when the 9th-bit sio_c falls: register updated, wr_evt_o pulses one cycle, wr_addr_o/wr_data_o updated; then -> IGNORE.
REQ-021 Writes with sub-address ≥ REG_DEPTH SHALL be dropped: no register change, no wr_evt_o.
REQ-022 RDATA: drive register[pointer] (8'h00 if out of range) for 8 bits, then release -> RD_NA; RD_NA ignores master's NA bit -> IGNORE.
REQ-023 Pointer SHALL persist across transactions (2-phase write then 2-phase read); pointer does not auto-increment.
REQ-024 SCCB write and host read of the same register in one cycle: host_rdata_o shows the old value that cycle.
REQ-025 A START with sio_c low or glitches shorter than 2 clk cycles SHALL be ignored.

Reset
REQ-026 On rst_n low: state IDLE, bit counter 0, pointer 8'h00, all registers 8'h00, sio_d released, wr_evt_o 0, wr_addr_o 8'h00, wr_data_o 8'h00, busy_o 0.
REQ-027 Reset mid-transaction SHALL release sio_d immediately; after release, the responder waits for a fresh START.

Configuration
REQ-028 Macro SCCB_SLV_ACK_EN: when defined, responder drives sio_d low during ID_ACK, SUB_ACK and WDATA_ACK 9th bits (addressed only); when undefined, sio_d is released in those bits (SCCB don't-care bit); all other behaviour identical.

Verification
REQ-029 START, 0x42, 0x01, 0x2A, STOP -> wr_evt_o one pulse, wr_addr_o=0x01, wr_data_o=0x2A; host_raddr_i=0x01 reads 0x2A.
REQ-030 After REQ-029: START 0x42 0x01 STOP, START 0x43 -> responder shifts 0x2A (0,0,1,0,1,0,1,0) then releases for NA; STOP -> busy_o 0.
REQ-031 START, 0x60, 0x01, 0x55, STOP -> sio_d never driven, no wr_evt_o, registers unchanged.
REQ-032 START 0x42 0x20 0x77 STOP (REG_DEPTH=16) -> no wr_evt_o; subsequent read of 0x20 returns 0x00.
REQ-033 rst_n asserted during RDATA bit 3 -> sio_d 'z' same cycle, all outputs at reset values; next 3-phase write 0x42 0x02 0x11 commits normally.
REQ-034 With SCCB_SLV_ACK_EN defined, 3-phase write -> sio_d low on all three 9th bits; undefined -> sio_d 'z' on all three.

Source files
------------

// File: rtl/sccb_slave_responder.sv
// SCCB slave register responder.
// Receives 3-phase writes (ID, sub-address, data) and 2-phase writes (ID, sub-address).
// A 2-phase write sets the register pointer. A following read (ID with R/W=1) then
// returns register[pointer]. sio_c and sio_d pass through 2-flop synchronisers and a
// two-sample stability filter. All bus decoding uses the filtered values.
// The responder only ever pulls sio_d low (open-drain). A '1' bit is a released line.
// Optional build macro: SCCB_SLV_ACK_EN. When it is defined, the responder pulls sio_d
// low on the 9th bit of ID, sub-address and write-data phases once it is addressed.
// When it is undefined, those bits are left released.
`timescale 1ns/1ps

module sccb_slave_responder #(
    parameter logic [6:0] SLAVE_ID  = 7'h21,
    parameter int         REG_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sio_c,
    inout  wire        sio_d,
    input  logic [7:0] host_raddr_i,
    output logic [7:0] host_rdata_o,
    output logic       wr_evt_o,
    output logic [7:0] wr_addr_o,
    output logic [7:0] wr_data_o,
    output logic       busy_o
);

    localparam int         AW     = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;
    localparam logic [8:0] DEPTH9 = 9'(REG_DEPTH);

`ifdef SCCB_SLV_ACK_EN
    localparam logic ACK_DRIVE = 1'b1;
`else
    localparam logic ACK_DRIVE = 1'b0;
`endif

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ID        = 4'd1,
        ST_ID_ACK    = 4'd2,
        ST_SUB       = 4'd3,
        ST_SUB_ACK   = 4'd4,
        ST_WDATA     = 4'd5,
        ST_WDATA_ACK = 4'd6,
        ST_RDATA     = 4'd7,
        ST_RD_NA     = 4'd8,
        ST_IGNORE    = 4'd9
    } state_t;

    // synchroniser, stability filter and edge-history registers
    logic c_meta_r, c_sync_r, c_sync_d_r, c_filt_r, c_filt_d_r;
    logic d_meta_r, d_sync_r, d_sync_d_r, d_filt_r, d_filt_d_r;

    // protocol state
    state_t     state_r;
    logic [3:0] bit_cnt_r;
    logic [7:0] shift_r;
    logic [7:0] ptr_r;
    logic [7:0] wdata_r;
    logic [6:0] rd_shift_r;
    logic       rw_r;
    logic       sda_low_r;
    logic [7:0] regs_r [REG_DEPTH];

    // decoded bus events and pointer lookups
    logic       c_rise_s;
    logic       c_fall_s;
    logic       start_s;
    logic       stop_s;
    logic       ptr_in_range_s;
    logic [7:0] rd_byte_s;

    // Open-drain data line: pull low or release.
    assign sio_d = sda_low_r ? 1'b0 : 1'bz;

    // Two-flop synchronisers, then a filter that accepts a level only after two equal samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_meta_r   <= 1'b1;
            c_sync_r   <= 1'b1;
            c_sync_d_r <= 1'b1;
            c_filt_r   <= 1'b1;
            c_filt_d_r <= 1'b1;
            d_meta_r   <= 1'b1;
            d_sync_r   <= 1'b1;
            d_sync_d_r <= 1'b1;
            d_filt_r   <= 1'b1;
            d_filt_d_r <= 1'b1;
        end else begin
            c_meta_r   <= sio_c;
            c_sync_r   <= c_meta_r;
            c_sync_d_r <= c_sync_r;
            c_filt_d_r <= c_filt_r;
            if (c_sync_r == c_sync_d_r) begin
                c_filt_r <= c_sync_r;
            end
            d_meta_r   <= sio_d;
            d_sync_r   <= d_meta_r;
            d_sync_d_r <= d_sync_r;
            d_filt_d_r <= d_filt_r;
            if (d_sync_r == d_sync_d_r) begin
                d_filt_r <= d_sync_r;
            end
        end
    end

    // Bus condition decode from the filtered levels.
    always_comb begin
        c_rise_s = c_filt_r & ~c_filt_d_r;
        c_fall_s = ~c_filt_r & c_filt_d_r;
        start_s  = c_filt_r & c_filt_d_r & d_filt_d_r & ~d_filt_r;
        stop_s   = c_filt_r & c_filt_d_r & ~d_filt_d_r & d_filt_r;
    end

    // Pointer range check and the byte returned by a read (zero when out of range).
    always_comb begin
        ptr_in_range_s = ({1'b0, ptr_r} < DEPTH9);
        rd_byte_s      = 8'h00;
        if (ptr_in_range_s) begin
            rd_byte_s = regs_r[ptr_r[AW-1:0]];
        end else begin
            rd_byte_s = 8'h00;
        end
    end

    // Host read port: combinational lookup, zero outside the register file.
    always_comb begin
        host_rdata_o = 8'h00;
        if ({1'b0, host_raddr_i} < DEPTH9) begin
            host_rdata_o = regs_r[host_raddr_i[AW-1:0]];
        end else begin
            host_rdata_o = 8'h00;
        end
    end

    // Protocol FSM.
    // Bits are sampled on sio_c rise and the drive changes on sio_c fall.
    // START and STOP override any state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            bit_cnt_r  <= 4'd0;
            shift_r    <= 8'h00;
            ptr_r      <= 8'h00;
            wdata_r    <= 8'h00;
            rd_shift_r <= 7'h00;
            rw_r       <= 1'b0;
            sda_low_r  <= 1'b0;
            wr_evt_o   <= 1'b0;
            wr_addr_o  <= 8'h00;
            wr_data_o  <= 8'h00;
            busy_o     <= 1'b0;
            for (int i = 0; i < REG_DEPTH; i++) begin
                regs_r[i] <= 8'h00;
            end
        end else begin
            wr_evt_o <= 1'b0;
            if (start_s) begin
                state_r   <= ST_ID;
                bit_cnt_r <= 4'd0;
                sda_low_r <= 1'b0;
                busy_o    <= 1'b1;
            end else if (stop_s) begin
                state_r   <= ST_IDLE;
                bit_cnt_r <= 4'd0;
                sda_low_r <= 1'b0;
                busy_o    <= 1'b0;
            end else if (c_rise_s) begin
                case (state_r)
                    ST_ID, ST_SUB, ST_WDATA: begin
                        shift_r <= {shift_r[6:0], d_filt_r};
                        if (bit_cnt_r != 4'd8) begin
                            bit_cnt_r <= bit_cnt_r + 4'd1;
                        end
                    end
                    ST_RDATA: begin
                        if (bit_cnt_r != 4'd8) begin
                            bit_cnt_r <= bit_cnt_r + 4'd1;
                        end
                    end
                    ST_ID_ACK, ST_SUB_ACK, ST_WDATA_ACK, ST_RD_NA: begin
                        bit_cnt_r <= 4'd1;
                    end
                    default: begin
                        bit_cnt_r <= bit_cnt_r;
                    end
                endcase
            end else if (c_fall_s) begin
                case (state_r)
                    ST_ID: begin
                        if (bit_cnt_r == 4'd8) begin
                            bit_cnt_r <= 4'd0;
                            if (shift_r[7:1] == SLAVE_ID) begin
                                state_r   <= ST_ID_ACK;
                                rw_r      <= shift_r[0];
                                sda_low_r <= ACK_DRIVE;
                            end else begin
                                state_r <= ST_IGNORE;
                            end
                        end
                    end
                    ST_ID_ACK: begin
                        if (bit_cnt_r == 4'd1) begin
                            bit_cnt_r <= 4'd0;
                            if (rw_r) begin
                                state_r    <= ST_RDATA;
                                rd_shift_r <= rd_byte_s[6:0];
                                sda_low_r  <= ~rd_byte_s[7];
                            end else begin
                                state_r   <= ST_SUB;
                                sda_low_r <= 1'b0;
                            end
                        end
                    end
                    ST_SUB: begin
                        if (bit_cnt_r == 4'd8) begin
                            bit_cnt_r <= 4'd0;
                            ptr_r     <= shift_r;
                            state_r   <= ST_SUB_ACK;
                            sda_low_r <= ACK_DRIVE;
                        end
                    end
                    ST_SUB_ACK: begin
                        if (bit_cnt_r == 4'd1) begin
                            bit_cnt_r <= 4'd0;
                            state_r   <= ST_WDATA;
                            sda_low_r <= 1'b0;
                        end
                    end
                    ST_WDATA: begin
                        if (bit_cnt_r == 4'd8) begin
                            bit_cnt_r <= 4'd0;
                            wdata_r   <= shift_r;
                            state_r   <= ST_WDATA_ACK;
                            sda_low_r <= ACK_DRIVE;
                        end
                    end
                    ST_WDATA_ACK: begin
                        if (bit_cnt_r == 4'd1) begin
                            bit_cnt_r <= 4'd0;
                            state_r   <= ST_IGNORE;
                            sda_low_r <= 1'b0;
                            // Commit point: the 9th bit of the data phase has completed.
                            if (ptr_in_range_s) begin
                                regs_r[ptr_r[AW-1:0]] <= wdata_r;
                                wr_evt_o              <= 1'b1;
                                wr_addr_o             <= ptr_r;
                                wr_data_o             <= wdata_r;
                            end
                        end
                    end
                    ST_RDATA: begin
                        if (bit_cnt_r == 4'd8) begin
                            bit_cnt_r <= 4'd0;
                            state_r   <= ST_RD_NA;
                            sda_low_r <= 1'b0;
                        end else begin
                            sda_low_r  <= ~rd_shift_r[6];
                            rd_shift_r <= {rd_shift_r[5:0], 1'b0};
                        end
                    end
                    ST_RD_NA: begin
                        if (bit_cnt_r == 4'd1) begin
                            bit_cnt_r <= 4'd0;
                            state_r   <= ST_IGNORE;
                        end
                    end
                    default: begin
                        sda_low_r <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
